type_buffer: RTL
================

// Module: type_buffer
// PURPOSE
//  Writer side of the packed-text interface that vga consumes: turns decoded key events into the
//  packed typed-text array (type), the current-word length (tot) and the matching-prefix count
//  (correct) against the dictionary word being typed. Sits between the keyboard decoder and vga.
//  Also produces word-commit pulses and keystroke/error counters for the WPM and accuracy logic.
// PARAMETERS
//  MAXLEN  25   typed-buffer capacity in characters (type width = 5*MAXLEN)
//  TLEN    15   target-word capacity in characters (target width = 5*TLEN)
//  CNTW    10   width of keystroke/error/word counters
// PORTS
//  clk         in   1         system clock
//  rst_n       in   1         asynchronous reset, active low
//  clear       in   1         start new round: sync wipe of buffer, counters and FSM
//  key_valid   in   1         one-cycle strobe: key_char holds a new key
//  key_char    in   5         1..26 = a..z, 0 = space (commit); 27..31 ignored
//  key_bs      in   1         one-cycle backspace strobe
//  target      in   5*TLEN    current dictionary word, char i at [5i+:5], 1..26 per char
//  target_len  in   5         length of target (1..TLEN)
//  type        out  5*MAXLEN  typed chars, char i at [5i+:5], unused slots 0
//  tot         out  5         chars in current word (0..MAXLEN)
//  correct     out  5         leading positions matching target (0..min(tot,target_len))
//  started     out  1         high from first letter after reset/clear
//  word_done   out  1         one-cycle pulse on successful commit
//  overflow    out  1         one-cycle pulse when a letter is dropped because buffer is full
//  keystrokes  out  CNTW      letters accepted since clear (saturating)
//  errors      out  CNTW      wrong letters + bad commits since clear (saturating)
//  words       out  CNTW      committed words since clear (saturating)
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0, FSM=IDLE. clear (sync) gives identical state next cycle.
//  Priority per cycle: clear > key_bs > key_valid. bs+valid same cycle: bs applied, key dropped.
//  FSM: IDLE -(letter)-> TYPE ; TYPE -(good space)-> COMMIT ; COMMIT -(1 cycle)-> TYPE ;
//       any -(clear)-> IDLE. Space or bs in IDLE: no effect, no counting.
//  Letter, tot<MAXLEN: type[5*tot+:5]<=key_char, tot<=tot+1, keystrokes++; errors++ if
//    tot>=target_len or key_char != target[5*tot+:5]. started<=1.
//  Letter, tot==MAXLEN: buffer unchanged, not counted, overflow=1 for one cycle.
//  key_char 27..31: ignored entirely.
//  key_bs, tot>0: slot tot-1 cleared to 0, tot<=tot-1; counters unchanged. tot==0: no effect.
//  Space in TYPE: good iff tot==target_len and correct==target_len -> state COMMIT; in that cycle
//    word_done=1, type<=0, tot<=0, words++. Otherwise errors++, buffer unchanged.
//  Key events arriving while in COMMIT are processed normally (buffer already cleared).
//  correct: registered, computed from type/tot/target of previous cycle -> 1-cycle latency after
//    any buffer or target change; counts i from 0 while i<tot, i<target_len, chars equal; stops
//    at first mismatch.
//  Counters saturate at 2^CNTW-1, never wrap. tot never exceeds MAXLEN, never underflows.
//  word_done/overflow are pulses, cleared the following cycle unless re-triggered.
//  rst_n asserted mid-word: everything cleared immediately, no word_done emitted.
// TESTING
//  1 target "cat"(3,1,20) len 3; keys 3,1,20 then space -> type low 15b={20,1,3}, correct=3
//    one cycle later, word_done pulse, then tot=0, type=0, words=1, errors=0, keystrokes=3.
//  2 keys 3,2 -> correct=1, errors=1; bs -> tot=1, slot1=0, correct=1; key 1 -> correct=2.
//  3 space with tot=2 on target len 3 -> no word_done, errors+1, buffer unchanged.
//  4 25 letters then 26th -> tot stays 25, overflow pulse, keystrokes=25; 26 bs -> tot=0, no wrap.
//  5 key_valid+key_bs same cycle at tot=2 -> tot=1, keystrokes unchanged; clear -> all 0, IDLE.
//  6 rst_n low mid-word (async, between edges) -> outputs 0 immediately; errors saturate at 1023.

Source files
------------

// File: rtl/type_buffer_if.sv
// Key-event, target-word and typed-text signals shared between the keyboard side and type_buffer.
// The typed-text array is named type_data because "type" is a reserved word in SystemVerilog.
interface type_buffer_if #(
  parameter int unsigned MAXLEN = 25,
  parameter int unsigned TLEN   = 15,
  parameter int unsigned CNTW   = 10
);
  logic                  clear;
  logic                  key_valid;
  logic [4:0]            key_char;
  logic                  key_bs;
  logic [5*TLEN-1:0]     target;
  logic [4:0]            target_len;
  logic [5*MAXLEN-1:0]   type_data;
  logic [4:0]            tot;
  logic [4:0]            correct;
  logic                  started;
  logic                  word_done;
  logic                  overflow;
  logic [CNTW-1:0]       keystrokes;
  logic [CNTW-1:0]       errors;
  logic [CNTW-1:0]       words;

  modport master (
    output clear, key_valid, key_char, key_bs, target, target_len,
    input  type_data, tot, correct, started, word_done, overflow,
           keystrokes, errors, words
  );

  modport slave (
    input  clear, key_valid, key_char, key_bs, target, target_len,
    output type_data, tot, correct, started, word_done, overflow,
           keystrokes, errors, words
  );
endinterface

// File: rtl/type_buffer.sv
// Turns decoded key events into the packed typed-text buffer, word length, matching-prefix
// count, commit pulses and saturating keystroke/error/word counters.
module type_buffer #(
  parameter int unsigned MAXLEN = 25,
  parameter int unsigned TLEN   = 15,
  parameter int unsigned CNTW   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  type_buffer_if.slave bus
);
  localparam int unsigned CMPN = (MAXLEN < TLEN) ? MAXLEN : TLEN;

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_COMMIT} state_t;

  state_t              state, state_next;
  logic [5*MAXLEN-1:0] buf_q;
  logic [4:0]          tot, correct, correct_next;
  logic                started, word_done, overflow;
  logic [CNTW-1:0]     keys, errs, words;
  logic [4:0]          tgt_char;
  logic                run, letter_err;
  logic                do_add, do_ovf, do_bs, do_good, do_bad;

  assign bus.type_data  = buf_q;
  assign bus.tot        = tot;
  assign bus.correct    = correct;
  assign bus.started    = started;
  assign bus.word_done  = word_done;
  assign bus.overflow   = overflow;
  assign bus.keystrokes = keys;
  assign bus.errors     = errs;
  assign bus.words      = words;

  // Prefix match of the buffer against the target as it stands this cycle; registered below.
  always_comb begin
    correct_next = '0;
    run          = 1'b1;
    for (int unsigned i = 0; i < CMPN; i++) begin
      if (run && i < 32'(tot) && i < 32'(bus.target_len) &&
          buf_q[5*i +: 5] == bus.target[5*i +: 5])
        correct_next = correct_next + 5'd1;
      else
        run = 1'b0;
    end
  end

  always_comb begin
    tgt_char = '0;
    for (int unsigned i = 0; i < TLEN; i++)
      if (32'(tot) == i) tgt_char = bus.target[5*i +: 5];
    letter_err = (tot >= bus.target_len) || (bus.key_char != tgt_char);
  end

  always_comb begin
    state_next = state;
    do_add     = 1'b0;
    do_ovf     = 1'b0;
    do_bs      = 1'b0;
    do_good    = 1'b0;
    do_bad     = 1'b0;
    if (bus.clear) begin
      state_next = S_IDLE;
    end else begin
      if (state == S_COMMIT) state_next = S_TYPE;
      if (bus.key_bs) begin
        do_bs = (tot != '0);
      end else if (bus.key_valid) begin
        if (bus.key_char >= 5'd1 && bus.key_char <= 5'd26) begin
          if (32'(tot) < MAXLEN) begin
            do_add     = 1'b1;
            state_next = S_TYPE;
          end else begin
            do_ovf = 1'b1;
          end
        end else if (bus.key_char == '0 && state != S_IDLE) begin
          // Commit decision uses the registered prefix count, i.e. last cycle's buffer.
          if (tot == bus.target_len && correct == bus.target_len) begin
            do_good    = 1'b1;
            state_next = S_COMMIT;
          end else begin
            do_bad = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q     <= '0;
      tot       <= '0;
      correct   <= '0;
      started   <= 1'b0;
      word_done <= 1'b0;
      overflow  <= 1'b0;
      keys      <= '0;
      errs      <= '0;
      words     <= '0;
    end else if (bus.clear) begin
      buf_q     <= '0;
      tot       <= '0;
      correct   <= '0;
      started   <= 1'b0;
      word_done <= 1'b0;
      overflow  <= 1'b0;
      keys      <= '0;
      errs      <= '0;
      words     <= '0;
    end else begin
      word_done <= do_good;
      overflow  <= do_ovf;
      correct   <= correct_next;
      if (do_add) begin
        for (int unsigned i = 0; i < MAXLEN; i++)
          if (32'(tot) == i) buf_q[5*i +: 5] <= bus.key_char;
        tot     <= tot + 5'd1;
        started <= 1'b1;
        if (keys != '1) keys <= keys + CNTW'(1);
        if (letter_err && errs != '1) errs <= errs + CNTW'(1);
      end
      if (do_bs) begin
        for (int unsigned i = 0; i < MAXLEN; i++)
          if (32'(tot) == i + 1) buf_q[5*i +: 5] <= '0;
        tot <= tot - 5'd1;
      end
      if (do_bad && errs != '1) errs <= errs + CNTW'(1);
      if (do_good) begin
        buf_q <= '0;
        tot   <= '0;
        if (words != '1) words <= words + CNTW'(1);
      end
    end
  end
endmodule
